// File: rtl/fir_coeff_loader_if.sv
// fir_coeff_loader_if
//   Port-A connection between the FIR coefficient loader and the coefficient RAM.
//   master modport (loader side):
//     bram_en_a    out  port-A enable
//     bram_we      out  port-A write enable
//     bram_addr    out  port-A address
//     bram_wr_data out  port-A write data
//     bram_rd_data in   port-A read data
//   slave modport (RAM side): same signals, opposite directions.
interface fir_coeff_loader_if #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
);
   logic              bram_en_a;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_wr_data;
   logic [DATA_W-1:0] bram_rd_data;

   modport master (
      output bram_en_a, bram_we, bram_addr, bram_wr_data,
      input  bram_rd_data
   );

   modport slave (
      input  bram_en_a, bram_we, bram_addr, bram_wr_data,
      output bram_rd_data
   );
endinterface

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader
//   Copies a tap set from the coefficient RAM (port A, read-only use) into the
//   FIR shadow coefficient registers, then commits it on a FIR frame boundary.
//   Optional feature macro: FIR_COEFF_CHECKSUM_EN (running checksum of loaded
//   words; when undefined the checksum output is tied to 0).
// Ports:
//   clk, rst      fabric clock, asynchronous active-high reset
//   load_req      single-cycle load request
//   base_addr     first RAM word of the tap set (sampled on accept)
//   num_taps      number of taps (sampled on accept)
//   fir_sync      FIR frame-boundary pulse
//   bram          port-A master (enable, address, constant write side, read data)
//   coeff_wr      shadow-register write strobe
//   coeff_idx     tap index of the current write
//   coeff_data    tap value of the current write
//   coeff_commit  one-cycle pulse: FIR swaps shadow to active
//   busy          load in progress
//   done          one-cycle completion pulse (coincides with coeff_commit)
//   err_busy      sticky: load_req seen while busy
//   err_zero      sticky: load_req seen with num_taps == 0
//   checksum      running sum of loaded words (modulo 2^DATA_W)
module fir_coeff_loader #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load_req,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   num_taps,
   input  logic                fir_sync,
   fir_coeff_loader_if.master  bram,
   output logic                coeff_wr,
   output logic [ADDR_W-1:0]   coeff_idx,
   output logic [DATA_W-1:0]   coeff_data,
   output logic                coeff_commit,
   output logic                busy,
   output logic                done,
   output logic                err_busy,
   output logic                err_zero,
   output logic [DATA_W-1:0]   checksum
);

   typedef enum logic [2:0] {IDLE, READ, DRAIN, WAIT_SYNC, COMMIT} state_t;

   // Oldest stage of the in-flight tracker; a read in this stage returns this cycle.
   localparam logic [RD_LAT-1:0] LAST_STAGE = RD_LAT'(1) << (RD_LAT - 1);

   state_t            state;
   logic              en;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] remain;
   logic [ADDR_W-1:0] idx;
   logic [RD_LAT-1:0] vld;
   logic              busy_r;
   logic              commit_r;
   logic              err_busy_r;
   logic              err_zero_r;
   logic              accept;

   assign accept = (state == IDLE) && load_req && (num_taps != '0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         en         <= 1'b0;
         addr       <= '0;
         remain     <= '0;
         busy_r     <= 1'b0;
         commit_r   <= 1'b0;
         err_busy_r <= 1'b0;
         err_zero_r <= 1'b0;
      end else begin
         commit_r <= 1'b0;
         if (load_req && state != IDLE)
            err_busy_r <= 1'b1;
         case (state)
            IDLE: begin
               if (load_req) begin
                  if (num_taps == '0) begin
                     err_zero_r <= 1'b1;
                  end else begin
                     addr       <= base_addr;
                     remain     <= num_taps;
                     en         <= 1'b1;
                     busy_r     <= 1'b1;
                     err_busy_r <= 1'b0;
                     err_zero_r <= 1'b0;
                     state      <= READ;
                  end
               end
            end
            READ: begin
               // Address wraps naturally at 2^ADDR_W.
               addr   <= addr + ADDR_W'(1);
               remain <= remain - ADDR_W'(1);
               if (remain == ADDR_W'(1)) begin
                  en    <= 1'b0;
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               // Leave once only the read returning this cycle (if any) is left.
               if ((vld & ~LAST_STAGE) == '0)
                  state <= WAIT_SYNC;
            end
            WAIT_SYNC: begin
               if (fir_sync) begin
                  commit_r <= 1'b1;
                  state    <= COMMIT;
               end
            end
            COMMIT: begin
               busy_r <= 1'b0;
               state  <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read-return tracking: one valid bit per cycle of port-A latency.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld <= '0;
         idx <= '0;
      end else begin
         vld <= (vld << 1) | RD_LAT'(en);
         if (accept)
            idx <= '0;
         else if (coeff_wr)
            idx <= idx + ADDR_W'(1);
      end
   end

   assign bram.bram_en_a    = en;
   assign bram.bram_we      = 1'b0;
   assign bram.bram_addr    = addr;
   assign bram.bram_wr_data = '0;

   // Index/data are forced to 0 outside write strobes so that reset zeroes them at once.
   assign coeff_wr     = vld[RD_LAT-1];
   assign coeff_idx    = coeff_wr ? idx : '0;
   assign coeff_data   = coeff_wr ? bram.bram_rd_data : '0;
   assign coeff_commit = commit_r;
   assign done         = commit_r;
   assign busy         = busy_r;
   assign err_busy     = err_busy_r;
   assign err_zero     = err_zero_r;

`ifdef FIR_COEFF_CHECKSUM_EN
   logic [DATA_W-1:0] sum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sum <= '0;
      else if (accept)
         sum <= '0;
      else if (coeff_wr)
         sum <= sum + bram.bram_rd_data;
   end

   assign checksum = sum;
`else
   assign checksum = '0;
`endif

endmodule

// File: tb/tb_fir_coeff_loader.sv
// tb_fir_coeff_loader
//   Plans a timeline of loads from the timing rules (accept, reads, returns,
//   sync, commit), drives it cycle by cycle and compares every DUT output on
//   the falling edge against the planned expectations.
module tb_fir_coeff_loader;
   localparam int AW   = 10;
   localparam int DW   = 32;
   localparam int RL   = 2;
   localparam int MAXC = 4000;
`ifdef FIR_COEFF_CHECKSUM_EN
   localparam bit CS = 1'b1;
`else
   localparam bit CS = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          load_req = 1'b0;
   logic          fir_sync = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [AW-1:0] num_taps = '0;
   logic          coeff_wr, coeff_commit, busy, done, err_busy, err_zero;
   logic [AW-1:0] coeff_idx;
   logic [DW-1:0] coeff_data, checksum;

   fir_coeff_loader_if #(.ADDR_W(AW), .DATA_W(DW)) bram_if ();

   fir_coeff_loader #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RL)) dut (
      .clk          (clk),
      .rst          (rst),
      .load_req     (load_req),
      .base_addr    (base_addr),
      .num_taps     (num_taps),
      .fir_sync     (fir_sync),
      .bram         (bram_if.master),
      .coeff_wr     (coeff_wr),
      .coeff_idx    (coeff_idx),
      .coeff_data   (coeff_data),
      .coeff_commit (coeff_commit),
      .busy         (busy),
      .done         (done),
      .err_busy     (err_busy),
      .err_zero     (err_zero),
      .checksum     (checksum)
   );

   always #5 clk = ~clk;

   // Coefficient RAM with two output register stages (read latency 2).
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] ram_p1 = '0;
   logic [DW-1:0] ram_q  = '0;
   always @(posedge clk) begin
      if (bram_if.bram_en_a) ram_p1 <= ram[bram_if.bram_addr];
      ram_q <= ram_p1;
   end
   assign bram_if.bram_rd_data = ram_q;

   // Planned stimulus per cycle.
   bit          d_req [MAXC];
   bit [AW-1:0] d_base[MAXC];
   bit [AW-1:0] d_n   [MAXC];
   bit          d_sync[MAXC];
   bit          d_rst [MAXC];
   // Expected outputs per cycle.
   bit          e_en[MAXC], e_wr[MAXC], e_commit[MAXC], e_busy[MAXC], e_eb[MAXC], e_ez[MAXC];
   bit [AW-1:0] e_addr[MAXC], e_idx[MAXC];
   bit [DW-1:0] e_data[MAXC], e_sum[MAXC];

   int cyc = -1;
   int cur = 3;
   int end_cyc = 0;
   int total = 0;
   int bad = 0;
   int l1, l2, l3, l4, lr;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   // One load accepted at cycle 'cur'. n taps from base; real sync dly cycles
   // after WAIT_SYNC entry; optional request while busy at offset breq_off;
   // optional stray syncs during READ/DRAIN; gap idle cycles after commit.
   task automatic plan_load(input int base, input int n, input int dly,
                            input int breq_off, input bit strays, input int gap);
      int t, ws, sc, c, r, w;
      bit [DW-1:0] s;
      bit [AW-1:0] a;
      t = cur;
      d_req[t] = 1'b1; d_base[t] = AW'(base); d_n[t] = AW'(n);
      if (n == 0) begin
         for (int i = t + 1; i < MAXC; i++) e_ez[i] = 1'b1;
         cur = t + 1 + gap;
         return;
      end
      for (int i = t + 1; i < MAXC; i++) begin e_eb[i] = 1'b0; e_ez[i] = 1'b0; end
      for (int k = 1; k <= n; k++) begin
         a = AW'(base + k - 1);
         e_en[t+k] = 1'b1; e_addr[t+k] = a;
         w = t + k + RL;
         e_wr[w] = 1'b1; e_idx[w] = AW'(k - 1); e_data[w] = ram[a];
      end
      s = '0;
      for (int i = t + 1; i < MAXC; i++) begin
         e_sum[i] = s;
         if (e_wr[i]) s = s + e_data[i];
      end
      ws = t + n + RL + 1;
      sc = ws + dly;
      d_sync[sc] = 1'b1;
      c = sc + 1;
      e_commit[c] = 1'b1;
      for (int i = t + 1; i <= c; i++) e_busy[i] = 1'b1;
      if (strays) repeat (3) d_sync[$urandom_range(ws - 1, t + 1)] = 1'b1;
      if (breq_off >= 0) begin
         r = t + 1 + breq_off;
         if (r > c) r = c;
         d_req[r] = 1'b1; d_base[r] = AW'($urandom); d_n[r] = AW'($urandom_range(50, 1));
         for (int i = r + 1; i < MAXC; i++) e_eb[i] = 1'b1;
      end
      cur = c + 1 + gap;
   endtask

   // Load that is killed by reset 'kill' cycles into READ.
   task automatic plan_reset(input int base, input int n, input int kill);
      int t, r;
      t = cur;
      plan_load(base, n, 2, -1, 1'b0, 0);
      r = t + 1 + kill;
      for (int i = r; i < cur; i++) begin
         e_en[i] = 1'b0; e_wr[i] = 1'b0; e_commit[i] = 1'b0; e_busy[i] = 1'b0;
         d_req[i] = 1'b0; d_sync[i] = 1'b0;
      end
      for (int i = r; i < MAXC; i++) begin e_eb[i] = 1'b0; e_ez[i] = 1'b0; e_sum[i] = '0; end
      d_rst[r] = 1'b1;
      lr = r;
      cur = r + 2;
   endtask

   task automatic plan_all();
      int n;
      for (int i = 0; i < (1 << AW); i++) ram[i] = $urandom;
      for (int i = 0; i < 4; i++) ram[i] = DW'(i + 1);
      d_rst[0] = 1'b1; d_rst[1] = 1'b1;
      l1 = cur; plan_load(0, 4, 5, -1, 1'b0, 2);
      l2 = cur; plan_load(1022, 4, 0, -1, 1'b0, 1);
      l3 = cur; plan_load($urandom_range(1023, 0), 8, 1, 1, 1'b0, 0);
      l4 = cur; plan_load(7, 0, 0, -1, 1'b0, 2);
      plan_load($urandom_range(1023, 0), 5, 0, -1, 1'b1, 1);
      plan_reset($urandom_range(1023, 0), 8, 3);
      plan_load($urandom_range(1023, 0), 2, 1, -1, 1'b0, 2);
      while (cur < 2600) begin
         n = ($urandom_range(9, 0) == 0) ? 0 : int'($urandom_range(40, 1));
         plan_load($urandom_range(1023, 0), n, $urandom_range(6, 0),
                   ($urandom_range(2, 0) == 0) ? int'($urandom_range(n + 8, 0)) : -1,
                   1'($urandom_range(1, 0)), $urandom_range(3, 0));
      end
      plan_load($urandom_range(1023, 0), 1023, 1, -1, 1'b0, 0);
      end_cyc = cur + 10;
   endtask

   initial begin
      plan_all();
      while (cyc < end_cyc) begin
         @(posedge clk);
         cyc++;
         #1;
         rst       = d_rst[cyc];
         load_req  = d_req[cyc];
         base_addr = d_base[cyc];
         num_taps  = d_n[cyc];
         fir_sync  = d_sync[cyc];
      end
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   always @(negedge clk) begin
      if (cyc >= 0 && cyc < MAXC) begin
         chk("bram_en_a", 32'(bram_if.bram_en_a), 32'(e_en[cyc]));
         if (e_en[cyc]) chk("bram_addr", 32'(bram_if.bram_addr), 32'(e_addr[cyc]));
         chk("bram_we", 32'(bram_if.bram_we), 32'd0);
         chk("bram_wr_data", bram_if.bram_wr_data, 32'd0);
         chk("coeff_wr", 32'(coeff_wr), 32'(e_wr[cyc]));
         if (e_wr[cyc]) begin
            chk("coeff_idx", 32'(coeff_idx), 32'(e_idx[cyc]));
            chk("coeff_data", coeff_data, e_data[cyc]);
         end
         chk("coeff_commit", 32'(coeff_commit), 32'(e_commit[cyc]));
         chk("done", 32'(done), 32'(e_commit[cyc]));
         chk("busy", 32'(busy), 32'(e_busy[cyc]));
         chk("err_busy", 32'(err_busy), 32'(e_eb[cyc]));
         chk("err_zero", 32'(err_zero), 32'(e_ez[cyc]));
         chk("checksum", checksum, CS ? e_sum[cyc] : 32'd0);
         if (d_rst[cyc]) begin
            chk("rst_coeff_data", coeff_data, 32'd0);
            chk("rst_coeff_idx", 32'(coeff_idx), 32'd0);
            chk("rst_bram_addr", 32'(bram_if.bram_addr), 32'd0);
         end
         // Hand-computed anchors for the directed loads.
         if (cyc == l1 + 3) begin
            chk("lit_first_wr", 32'(coeff_wr), 32'd1);
            chk("lit_first_data", coeff_data, 32'd1);
         end
         if (cyc == l1 + 6) begin
            chk("lit_last_data", coeff_data, 32'd4);
            chk("lit_last_idx", 32'(coeff_idx), 32'd3);
         end
         if (cyc == l1 + 7) chk("lit_checksum", checksum, CS ? 32'd10 : 32'd0);
         if (cyc == l1 + 12) chk("lit_no_early_commit", 32'(coeff_commit), 32'd0);
         if (cyc == l1 + 13) chk("lit_done", 32'(done), 32'd1);
         if (cyc == l2 + 2) chk("lit_addr_1023", 32'(bram_if.bram_addr), 32'd1023);
         if (cyc == l2 + 3) chk("lit_addr_wrap", 32'(bram_if.bram_addr), 32'd0);
         if (cyc == l3 + 3) chk("lit_err_busy", 32'(err_busy), 32'd1);
         if (cyc == l4 + 1) begin
            chk("lit_err_zero", 32'(err_zero), 32'd1);
            chk("lit_zero_busy", 32'(busy), 32'd0);
         end
         if (cyc == lr) chk("lit_rst_busy", 32'(busy), 32'd0);
         if (done) $display("txn: commit at cycle %0d checksum=%0h", cyc, checksum);
      end
   end
endmodule

// File: doc/fir_coeff_loader.md
# fir_coeff_loader

Sequencer that transfers a programmed tap set from the single-channel FIR coefficient RAM, read through the fabric-side port A, into the FIR's shadow coefficient registers. It then commits the new set on a FIR frame boundary. It sits between the coefficient RAM block and the programmable FIR. Software writes coefficients through the processor-side port, then pulses a load request through a control register.

## Interface
- ADDR_W, 10, coefficient RAM address width (1024 words)
- DATA_W, 32, coefficient word width
- RD_LAT, 2, port-A read latency in cycles (core and primitive output registers enabled)
- clk  in  1  fabric clock, shared with RAM port A and the FIR
- rst  in  1  asynchronous, active-high reset
- load_req  in  1  single-cycle request to start a load
- base_addr  in  ADDR_W  first RAM word of the tap set, sampled on an accepted load_req
- num_taps  in  ADDR_W  number of taps to transfer, sampled on an accepted load_req
- fir_sync  in  1  FIR frame-boundary pulse
- bram_en_a  out  1  port-A enable
- bram_we  out  1  port-A write enable; constant 0
- bram_addr  out  ADDR_W  port-A address
- bram_wr_data  out  DATA_W  constant 0
- bram_rd_data  in  DATA_W  port-A read data
- coeff_wr  out  1  shadow-register write strobe
- coeff_idx  out  ADDR_W  tap index 0..num_taps-1
- coeff_data  out  DATA_W  tap value
- coeff_commit  out  1  one-cycle pulse: FIR swaps shadow to active
- busy  out  1  load in progress
- done  out  1  one-cycle completion pulse
- err_busy  out  1  sticky: load_req arrived while busy
- err_zero  out  1  sticky: load_req arrived with num_taps==0
- checksum  out  DATA_W  running sum of loaded words

## Operation
- States:
  - IDLE. load_req with num_taps!=0: latch base_addr/num_taps, clear both sticky errors, clear checksum, go to READ. load_req with num_taps==0: set err_zero, stay in IDLE; no reads, no commit, no done.
  - READ. Assert bram_en_a with bram_addr = base+i, i = 0..num_taps-1, one read per cycle. Address wraps modulo 2^ADDR_W (base 1020, 8 taps reads 1020..1023, 0..3). After the last issue go to DRAIN.
  - DRAIN. Wait until every in-flight read has returned (RD_LAT-deep valid shift register empty), then go to WAIT_SYNC.
  - WAIT_SYNC. On the first fir_sync sampled in this state go to COMMIT.
  - COMMIT. Pulse coeff_commit and done together, return to IDLE.
- Read return: each issued read returns exactly RD_LAT cycles later. On return, drive coeff_wr=1, coeff_data=bram_rd_data, coeff_idx=i, and add the word to checksum.
- load_req while busy: ignored, err_busy set; the current load is unaffected.
- Arithmetic: checksum is modulo 2^DATA_W. Index and address counters are ADDR_W wide. num_taps max is 2^ADDR_W-1.
- fir_sync outside WAIT_SYNC is ignored.

## Timing
- Reset values: all outputs 0, state IDLE. checksum 0, sticky errors 0.
- load_req accepted in cycle 0; first bram_en_a in cycle 1; last in cycle N.
- coeff_wr in cycles 1+RD_LAT .. N+RD_LAT, contiguous.
- WAIT_SYNC is entered in cycle N+RD_LAT+1. For fir_sync sampled in cycle S ≥ N+RD_LAT+1, coeff_commit and done occur in cycle S+1.
- busy: high in cycles 1 .. commit cycle inclusive; low in the cycle after commit. A new load_req is accepted in the cycle after commit.
- Reset mid-load: all activity stops immediately and no commit is issued. The FIR keeps its active set; shadow contents are undefined.

## Configuration
- FIR_COEFF_CHECKSUM_EN defined: checksum accumulates as described.
- FIR_COEFF_CHECKSUM_EN undefined: checksum is tied to 0 and no adder is built. All other behaviour is identical.

## Test plan
- base 0, num_taps 4, RAM[0..3]=1,2,3,4, fir_sync 5 cycles after drain -> coeff_wr in cycles 3..6 with idx 0..3 and data 1..4; commit/done one cycle after sync; checksum 10.
- base 1022, num_taps 4 -> bram_addr sequence 1022, 1023, 0, 1; idx 0..3.
- load_req in cycle 2 of an 8-tap load -> err_busy=1; exactly 8 coeff_wr and one commit.
- num_taps 0 -> err_zero=1, no bram_en_a, busy stays 0, no done.
- fir_sync pulsed during READ and DRAIN only -> no commit; first sync in WAIT_SYNC -> commit next cycle.
- rst asserted during READ -> all outputs 0 the same cycle; no commit; a subsequent 2-tap load completes normally.
